// File: rtl/dnn_mem_server_fix8.sv
// Byte-wide memory server for the fix8 DNN engine: one-cycle registered read port
// plus a host valid/ready load port that writes a contiguous range, stalled by mem_lock.
module dnn_mem_server_fix8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16'h2BC0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  input  logic                         mem_lock,
  input  logic                         ld_start,
  input  logic [ADDR_WIDTH-1:0]        ld_base,
  input  logic [ADDR_WIDTH-1:0]        ld_len,
  input  logic                         ld_valid,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  output logic                         ld_ready,
  output logic                         ld_busy,
  output logic                         ld_done,
  output logic                         ld_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LEN_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] LEN_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       state_r;
  state_t                       next_state_s;
  logic [IDX_W-1:0]             ptr_r;
  logic [ADDR_WIDTH-1:0]        cnt_r;
  logic                         ld_err_r;
  logic signed [DATA_WIDTH-1:0] mem_data_r;
  logic [DATA_WIDTH-1:0]        mem_r [DEPTH];

  logic [ADDR_WIDTH:0]          ld_end_s;
  logic                         range_err_s;
  logic                         start_s;
  logic                         ld_ready_s;
  logic                         xfer_s;
  logic                         rd_in_range_s;
  logic [IDX_W-1:0]             rd_idx_s;

  // Load FSM next state, handshake and range decode
  always_comb begin
    next_state_s  = state_r;
    ld_ready_s    = 1'b0;
    xfer_s        = 1'b0;
    start_s       = 1'b0;
    ld_end_s      = {1'b0, ld_base} + {1'b0, ld_len};
    range_err_s   = (ld_end_s > DEPTH_W);
    rd_in_range_s = ({1'b0, mem_addr} < DEPTH_W);
    rd_idx_s      = mem_addr[IDX_W-1:0];
    case (state_r)
      ST_IDLE: begin
        start_s = ld_start;
        if (ld_start) begin
          if (ld_len == LEN_ZERO) begin
            next_state_s = ST_DONE;
          end else if (range_err_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ld_ready_s = !mem_lock;
        xfer_s     = ld_valid && !mem_lock;
        if (xfer_s && (cnt_r == LEN_ONE)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Write pointer, remaining count and sticky range error; zero-length loads clear the error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r    <= {IDX_W{1'b0}};
      cnt_r    <= {ADDR_WIDTH{1'b0}};
      ld_err_r <= 1'b0;
    end else if (start_s) begin
      if (ld_len == LEN_ZERO) begin
        ld_err_r <= 1'b0;
      end else if (range_err_s) begin
        ld_err_r <= 1'b1;
      end else begin
        ptr_r    <= ld_base[IDX_W-1:0];
        cnt_r    <= ld_len;
        ld_err_r <= 1'b0;
      end
    end else if (xfer_s) begin
      ptr_r <= ptr_r + PTR_ONE;
      cnt_r <= cnt_r - LEN_ONE;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[ptr_r] <= ld_data;
    end
  end

  // Registered read; a same-cycle write is not forwarded, so the old byte is returned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_in_range_s) begin
      mem_data_r <= $signed(mem_r[rd_idx_s]);
    end else begin
      mem_data_r <= {DATA_WIDTH{1'b0}};
    end
  end

  assign mem_data = mem_data_r;
  assign ld_ready = ld_ready_s;
  assign ld_busy  = (state_r != ST_IDLE);
  assign ld_done  = (state_r == ST_DONE);
  assign ld_err   = ld_err_r;

endmodule

// File: tb/tb_dnn_mem_server_fix8.sv
// Directed bench for dnn_mem_server_fix8: a byte model supplies expected read data,
// queued when an address is driven and compared when the registered read returns.
module tb_dnn_mem_server_fix8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       mem_addr = 16'h0000;
  logic signed [7:0] mem_data;
  logic              mem_lock = 1'b0;
  logic              ld_start = 1'b0;
  logic [15:0]       ld_base = 16'h0000;
  logic [15:0]       ld_len = 16'h0000;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = 8'h00;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;

  int          checks = 0;
  int          failures = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  model_mem [int];
  logic [7:0]  exp_q [$];
  logic [7:0]  ld_bytes [8];

  dnn_mem_server_fix8 dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_lock (mem_lock),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err)
  );

  always #5 clk = ~clk;

  // Count completed ld_done pulses
  always @(posedge clk) begin
    if (ld_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] addr);
    if (addr >= 16'h2BC0) return 8'h00;
    if (model_mem.exists(int'(addr))) return model_mem[int'(addr)];
    return 8'h00;
  endfunction

  task automatic rd_check(input logic [15:0] addr, input string tag);
    mem_addr = addr;
    exp_q.push_back(model_rd(addr));
    tick();
    chk(tag, 32'($unsigned(mem_data)), 32'(exp_q.pop_front()));
  endtask

  // Load n bytes from ld_bytes at base; optionally hold mem_lock for stall_cyc cycles before byte stall_at
  task automatic do_load(input logic [15:0] base, input int n, input int stall_at, input int stall_cyc);
    int unsigned d0;
    d0 = done_cnt;
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = 16'(n);
    tick();
    ld_start = 1'b0;
    chk("load_busy", 32'(ld_busy), 32'd1);
    chk("load_err_clear", 32'(ld_err), 32'd0);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = ld_bytes[i];
      if (i == stall_at) begin
        mem_lock = 1'b1;
        for (int s = 0; s < stall_cyc; s++) begin
          #1;
          chk("stall_ready", 32'(ld_ready), 32'd0);
          tick();
        end
        mem_lock = 1'b0;
      end
      #1;
      chk("load_ready", 32'(ld_ready), 32'd1);
      tick();
      model_mem[int'(base) + i] = ld_bytes[i];
    end
    ld_valid = 1'b0;
    chk("done_pulse", 32'(ld_done), 32'd1);
    tick();
    chk("done_low", 32'(ld_done), 32'd0);
    chk("idle_after_done", 32'(ld_busy), 32'd0);
    chk("done_once", done_cnt, d0 + 32'd1);
  endtask

  initial begin
    // 1: reset held, outputs quiet while mem_addr moves
    for (int i = 0; i < 3; i++) begin
      mem_addr = 16'(i * 16'h0101);
      tick();
      chk("rst_mem_data", 32'($unsigned(mem_data)), 32'd0);
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      chk("rst_ld_err", 32'(ld_err), 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 32'(ld_busy), 32'd0);
    chk("post_rst_ready", 32'(ld_ready), 32'd0);

    // 2: basic 4-byte load, then read back
    ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33; ld_bytes[3] = 8'h44;
    do_load(16'h0191, 4, -1, 0);
    rd_check(16'h0193, "rd_0193");
    rd_check(16'h0191, "rd_0191");
    rd_check(16'h0194, "rd_0194");

    // 3: mem_lock stall after the first byte
    ld_bytes[0] = 8'hA1; ld_bytes[1] = 8'hB2; ld_bytes[2] = 8'hC3;
    do_load(16'h0400, 3, 1, 5);
    rd_check(16'h0400, "stall_rd0");
    rd_check(16'h0401, "stall_rd1");
    rd_check(16'h0402, "stall_rd2");

    // 4: range overflow rejected, exact fit accepted
    ld_start = 1'b1; ld_base = 16'h2BBE; ld_len = 16'd3;
    tick();
    ld_start = 1'b0;
    chk("range_err_set", 32'(ld_err), 32'd1);
    chk("range_not_busy", 32'(ld_busy), 32'd0);
    tick();
    chk("range_err_sticky", 32'(ld_err), 32'd1);
    ld_bytes[0] = 8'h7E; ld_bytes[1] = 8'h81;
    do_load(16'h2BBE, 2, -1, 0);
    rd_check(16'h2BBF, "rd_2BBF");
    rd_check(16'h2BBE, "rd_2BBE");

    // 5: write/read collision returns the old value first
    ld_bytes[0] = 8'h00;
    do_load(16'h0010, 1, -1, 0);
    mem_addr = 16'h0010;
    ld_start = 1'b1; ld_base = 16'h0010; ld_len = 16'd1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h5A;
    exp_q.push_back(model_rd(16'h0010));
    tick();
    model_mem[16] = 8'h5A;
    ld_valid = 1'b0;
    chk("collide_old", 32'($unsigned(mem_data)), 32'(exp_q.pop_front()));
    exp_q.push_back(model_rd(16'h0010));
    tick();
    chk("collide_new", 32'($unsigned(mem_data)), 32'(exp_q.pop_front()));
    chk("collide_idle", 32'(ld_busy), 32'd0);

    // 6a: zero-length load completes without writing
    ld_start = 1'b1; ld_base = 16'h0191; ld_len = 16'd0;
    tick();
    ld_start = 1'b0;
    chk("len0_done", 32'(ld_done), 32'd1);
    chk("len0_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("len0_done_low", 32'(ld_done), 32'd0);
    rd_check(16'h0191, "len0_nowrite");
    rd_check(16'hFFFF, "rd_ffff");
    rd_check(16'h2BC0, "rd_2BC0");

    // 6b: reset after two of four bytes aborts the load
    begin
      int unsigned d0;
      d0 = done_cnt;
      ld_start = 1'b1; ld_base = 16'h0300; ld_len = 16'd4;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b1; ld_data = 8'hE1;
      tick();
      model_mem[16'h0300] = 8'hE1;
      ld_data = 8'hE2;
      tick();
      model_mem[16'h0301] = 8'hE2;
      ld_data = 8'hE3;
      rst = 1'b0;
      #1;
      chk("abort_busy", 32'(ld_busy), 32'd0);
      chk("abort_ready", 32'(ld_ready), 32'd0);
      tick();
      rst = 1'b1;
      ld_valid = 1'b0;
      tick();
      tick();
      chk("abort_no_done", done_cnt, d0);
      chk("abort_idle", 32'(ld_busy), 32'd0);
      rd_check(16'h0300, "abort_kept0");
      rd_check(16'h0301, "abort_kept1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
